// File: rtl/mips_cpu_top.sv
// Single-cycle 32-bit MIPS subset core with internal instruction memory, data memory and register file.
// Optional I-type ALU instructions (addi/andi/ori/slti) are enabled by defining MIPS_IMM_ALU_EN.

module mips_ins_mem #(
    parameter int BYTES = 256,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    logic [7:0]    memory [BYTES];
    logic [AW-1:0] a1, a2, a3;
    logic [AW-1:0] l1, l2, l3;

    // byte offsets stay AW bits wide so fetches past the top wrap to address 0
    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign l1 = load_addr + AW'(1);
    assign l2 = load_addr + AW'(2);
    assign l3 = load_addr + AW'(3);

    assign instr = {memory[addr], memory[a1], memory[a2], memory[a3]};

    always_ff @(posedge clk) begin
        if (load_we) begin
            memory[load_addr] <= load_data[31:24];
            memory[l1]        <= load_data[23:16];
            memory[l2]        <= load_data[15:8];
            memory[l3]        <= load_data[7:0];
        end
    end
endmodule

module mips_data_mem #(
    parameter int BYTES = 256,
    parameter int AW    = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-3:0] word,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0]    memory [BYTES];
    logic [AW-1:0] b0, b1, b2, b3;

    assign b0 = {word, 2'b00};
    assign b1 = {word, 2'b01};
    assign b2 = {word, 2'b10};
    assign b3 = {word, 2'b11};

    assign rdata = {memory[b0], memory[b1], memory[b2], memory[b3]};

    always_ff @(posedge clk) begin
        if (we) begin
            memory[b0] <= wdata[31:24];
            memory[b1] <= wdata[23:16];
            memory[b2] <= wdata[15:8];
            memory[b3] <= wdata[7:0];
        end
    end
endmodule

module mips_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [32];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end
endmodule

module mips_cpu_top #(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out
);
    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic [31:0] simm, rs_data, rt_data, alu_b, alu_result, dmem_rdata, wb_data;

    logic    reg_we, store, reg_dst_rd, mem_to_reg, alu_b_imm, imm_zext, is_beq, is_j;
    alu_op_t alu_op;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign pc_out = pc;

    mips_ins_mem #(.BYTES(IMEM_BYTES)) my_ins_mem (
        .clk(clk), .load_we(1'b0), .load_addr('0), .load_data(32'd0),
        .addr(pc[IAW-1:0]), .instr(instr)
    );

    mips_reg_file my_reg_file (
        .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rs_data), .rd2(rt_data),
        .we(reg_we), .wa(wa), .wd(wb_data)
    );

    // stores are blocked while reset is asserted so a mid-program reset never corrupts memory
    mips_data_mem #(.BYTES(DMEM_BYTES)) data_mem (
        .clk(clk), .we(store && !rst), .word(alu_result[DAW-1:2]),
        .wdata(rt_data), .rdata(dmem_rdata)
    );

    always_comb begin
        reg_we     = 1'b0;
        store      = 1'b0;
        reg_dst_rd = 1'b0;
        mem_to_reg = 1'b0;
        alu_b_imm  = 1'b0;
        imm_zext   = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        alu_op     = ALU_ADD;
        case (op)
            6'h00: begin
                reg_dst_rd = 1'b1;
                reg_we     = 1'b1;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: reg_we = 1'b0;
                endcase
            end
            6'h23: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                alu_b_imm  = 1'b1;
            end
            6'h2B: begin
                store     = 1'b1;
                alu_b_imm = 1'b1;
            end
            6'h04: is_beq = 1'b1;
            6'h02: is_j   = 1'b1;
`ifdef MIPS_IMM_ALU_EN
            6'h08: begin
                reg_we    = 1'b1;
                alu_b_imm = 1'b1;
            end
            6'h0C: begin
                reg_we    = 1'b1;
                alu_b_imm = 1'b1;
                imm_zext  = 1'b1;
                alu_op    = ALU_AND;
            end
            6'h0D: begin
                reg_we    = 1'b1;
                alu_b_imm = 1'b1;
                imm_zext  = 1'b1;
                alu_op    = ALU_OR;
            end
            6'h0A: begin
                reg_we    = 1'b1;
                alu_b_imm = 1'b1;
                alu_op    = ALU_SLT;
            end
`endif
            default: ;
        endcase
    end

    assign alu_b = alu_b_imm ? (imm_zext ? {16'd0, imm} : simm) : rt_data;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = rs_data + alu_b;
            ALU_SUB: alu_result = rs_data - alu_b;
            ALU_AND: alu_result = rs_data & alu_b;
            ALU_OR:  alu_result = rs_data | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign wa      = reg_dst_rd ? rd : rt;
    assign wb_data = mem_to_reg ? dmem_rdata : alu_result;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (is_j)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (is_beq && rs_data == rt_data)
            pc_next = pc_plus4 + {simm[29:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else     pc <= pc_next;
    end
endmodule

// File: tb/tb_mips_cpu_top.sv
// Scoreboard bench for mips_cpu_top: programs are preloaded hierarchically, expectations queued, then compared.
module tb_mips_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          kind;   // 0 reg, 1 dmem word, 2 pc, 3 imem word
        int          addr;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];

    mips_cpu_top #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] observe(int kind, int addr);
        case (kind)
            0: return dut.my_reg_file.registers[addr];
            1: return {dut.data_mem.memory[addr], dut.data_mem.memory[addr+1],
                       dut.data_mem.memory[addr+2], dut.data_mem.memory[addr+3]};
            2: return pc_out;
            default: return {dut.my_ins_mem.memory[addr], dut.my_ins_mem.memory[addr+1],
                             dut.my_ins_mem.memory[addr+2], dut.my_ins_mem.memory[addr+3]};
        endcase
    endfunction

    task automatic expect_val(string name, int kind, int addr, logic [31:0] exp);
        sb_t e;
        e.name = name; e.kind = kind; e.addr = addr; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic put_i(int a, logic [31:0] w);
        dut.my_ins_mem.memory[a]   = w[31:24];
        dut.my_ins_mem.memory[a+1] = w[23:16];
        dut.my_ins_mem.memory[a+2] = w[15:8];
        dut.my_ins_mem.memory[a+3] = w[7:0];
    endtask

    task automatic put_d(int a, logic [31:0] w);
        dut.data_mem.memory[a]   = w[31:24];
        dut.data_mem.memory[a+1] = w[23:16];
        dut.data_mem.memory[a+2] = w[15:8];
        dut.data_mem.memory[a+3] = w[7:0];
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.my_ins_mem.memory[i] = 8'h00;
    endtask

    // leaves rst asserted at a falling edge so the caller can preload safely
    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        sb_t e;
        logic [31:0] act;
        clear_imem();
        for (int i = 0; i < 256; i++) dut.data_mem.memory[i] = 8'h00;
        put_d(4, 32'h0000_0001);
        put_i(0,  32'h8C80_0000);
        put_i(4,  32'h8C81_0004);
        put_i(8,  32'h0001_1020);
        put_i(12, 32'hAC81_0000);
        put_i(16, 32'hAC82_0004);
        put_i(20, 32'h0800_0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_val("reset_pc", 2, 0, 32'd0);
        for (int r = 0; r < 32; r++) expect_val($sformatf("reset_r%0d", r), 0, r, 32'd0);
        expect_val("reset_dmem_w1", 1, 4, 32'h0000_0001);
        expect_val("reset_imem_w0", 3, 0, 32'h8C80_0000);
        expect_val("reset_imem_w5", 3, 20, 32'h0800_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic test_program();
        sb_t e;
        logic [31:0] act;
        for (int pass = 0; pass < 2; pass++) begin
            run(5);
            expect_val($sformatf("prog%0d_pc", pass), 2, 0, 32'd20);
            expect_val($sformatf("prog%0d_r1", pass), 0, 1, 32'd1);
            expect_val($sformatf("prog%0d_r2", pass), 0, 2, 32'd1);
            expect_val($sformatf("prog%0d_r0", pass), 0, 0, 32'd0);
            expect_val($sformatf("prog%0d_w0", pass), 1, 0, 32'd1);
            expect_val($sformatf("prog%0d_w1", pass), 1, 4, 32'd1);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.kind, e.addr);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            run(1);
            expect_val($sformatf("prog%0d_loop_pc", pass), 2, 0, 32'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = observe(e.kind, e.addr);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    endtask

    task automatic test_alu();
        sb_t e;
        logic [31:0] act;
        logic [31:0] a = 32'd5;
        logic [31:0] b = 32'd7;
        logic [31:0] big = 32'h7FFF_FFFF;
        logic [31:0] d;
        hold_reset();
        clear_imem();
        put_d(8, a);
        put_d(12, b);
        put_d(20, big);
        put_d(24, 32'd1);
        put_i(0,  itype(6'h23, 5'd0, 5'd3, 16'd8));
        put_i(4,  itype(6'h23, 5'd0, 5'd4, 16'd12));
        put_i(8,  rtype(5'd3, 5'd4, 5'd5, 6'h2A));
        put_i(12, rtype(5'd3, 5'd4, 5'd6, 6'h22));
        put_i(16, rtype(5'd3, 5'd4, 5'd7, 6'h24));
        put_i(20, rtype(5'd3, 5'd4, 5'd8, 6'h25));
        put_i(24, rtype(5'd6, 5'd3, 5'd9, 6'h2A));
        put_i(28, rtype(5'd3, 5'd6, 5'd10, 6'h2A));
        put_i(32, rtype(5'd6, 5'd3, 5'd11, 6'h20));
        put_i(36, itype(6'h23, 5'd0, 5'd12, 16'd20));
        put_i(40, itype(6'h23, 5'd0, 5'd13, 16'd24));
        put_i(44, rtype(5'd12, 5'd13, 5'd14, 6'h20));
        put_i(48, itype(6'h23, 5'd0, 5'd15, 16'd21));
        put_i(52, rtype(5'd3, 5'd4, 5'd16, 6'h21));
        put_i(56, itype(6'h23, 5'd0, 5'd17, 16'h0108));
        rst = 1'b0;
        d = a - b;
        expect_val("alu_r3", 0, 3, a);
        expect_val("alu_r4", 0, 4, b);
        expect_val("slt_lt", 0, 5, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        expect_val("sub", 0, 6, d);
        expect_val("and", 0, 7, a & b);
        expect_val("or", 0, 8, a | b);
        expect_val("slt_neg_lt", 0, 9, ($signed(d) < $signed(a)) ? 32'd1 : 32'd0);
        expect_val("slt_ge", 0, 10, ($signed(a) < $signed(d)) ? 32'd1 : 32'd0);
        expect_val("add_wrap_neg", 0, 11, d + a);
        expect_val("add_overflow", 0, 14, big + 32'd1);
        expect_val("lw_unaligned", 0, 15, big);
        expect_val("bad_funct_nop", 0, 16, 32'd0);
        expect_val("lw_addr_wrap", 0, 17, a);
        expect_val("alu_pc", 2, 0, 32'd60);
        run(15);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic test_branch();
        sb_t e;
        logic [31:0] act;
        hold_reset();
        clear_imem();
        put_d(8, 32'd5);
        put_i(8,  itype(6'h04, 5'd0, 5'd0, 16'd2));
        put_i(12, itype(6'h23, 5'd0, 5'd1, 16'd8));
        rst = 1'b0;
        expect_val("beq_taken_pc", 2, 0, 32'd20);
        expect_val("beq_skipped_lw", 0, 1, 32'd0);
        run(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        hold_reset();
        clear_imem();
        put_i(0,  itype(6'h23, 5'd0, 5'd1, 16'd8));
        put_i(8,  itype(6'h04, 5'd1, 5'd0, 16'd2));
        put_i(12, itype(6'h04, 5'd0, 5'd0, 16'hFFFC));
        rst = 1'b0;
        run(3);
        expect_val("beq_not_taken_pc", 2, 0, 32'd12);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        run(1);
        expect_val("beq_backward_pc", 2, 0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic test_r0_and_jump();
        sb_t e;
        logic [31:0] act;
        hold_reset();
        clear_imem();
        put_d(8, 32'd5);
        put_i(0,  itype(6'h23, 5'd0, 5'd1, 16'd8));
        put_i(4,  rtype(5'd1, 5'd1, 5'd0, 6'h20));
        put_i(8,  itype(6'h23, 5'd0, 5'd0, 16'd8));
        put_i(12, {6'h02, 26'd64});
        rst = 1'b0;
        run(3);
        expect_val("r0_write_discarded", 0, 0, 32'd0);
        expect_val("r0_r1_loaded", 0, 1, 32'd5);
        expect_val("r0_pc", 2, 0, 32'd12);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        run(2);
        expect_val("jump_past_imem_pc", 2, 0, 32'd260);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic test_reset_during_store();
        sb_t e;
        logic [31:0] act;
        hold_reset();
        clear_imem();
        put_d(16, 32'hDEAD_BEEF);
        put_d(32, 32'h1122_3344);
        put_i(0, itype(6'h23, 5'd0, 5'd1, 16'd16));
        put_i(4, itype(6'h2B, 5'd0, 5'd1, 16'd32));
        rst = 1'b0;
        run(1);
        expect_val("pre_store_pc", 2, 0, 32'd4);
        expect_val("pre_store_r1", 0, 1, 32'hDEAD_BEEF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        expect_val("rst_store_suppressed", 1, 32, 32'h1122_3344);
        expect_val("rst_store_pc", 2, 0, 32'd0);
        expect_val("rst_store_r1", 0, 1, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        run(2);
        expect_val("store_after_rst", 1, 32, 32'hDEAD_BEEF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic test_imm_alu();
        sb_t e;
        logic [31:0] act;
        hold_reset();
        clear_imem();
        put_d(16, 32'h1234_5678);
        put_i(0,  itype(6'h23, 5'd0, 5'd1, 16'd16));
        put_i(4,  itype(6'h08, 5'd0, 5'd1, 16'hFFFF));
        put_i(8,  itype(6'h0D, 5'd0, 5'd2, 16'h8001));
        put_i(12, itype(6'h0C, 5'd1, 5'd3, 16'hF0F0));
        put_i(16, itype(6'h0A, 5'd1, 5'd4, 16'h0000));
        rst = 1'b0;
`ifdef MIPS_IMM_ALU_EN
        expect_val("addi_neg", 0, 1, 32'hFFFF_FFFF);
        expect_val("ori_zext", 0, 2, 32'h0000_8001);
        expect_val("andi_zext", 0, 3, 32'h0000_F0F0);
        expect_val("slti_signed", 0, 4, 32'd1);
`else
        expect_val("addi_nop", 0, 1, 32'h1234_5678);
        expect_val("ori_nop", 0, 2, 32'd0);
        expect_val("andi_nop", 0, 3, 32'd0);
        expect_val("slti_nop", 0, 4, 32'd0);
`endif
        expect_val("imm_pc", 2, 0, 32'd20);
        run(5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = observe(e.kind, e.addr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_alu();
        test_branch();
        test_r0_and_jump();
        test_reset_during_store();
        test_imm_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
